// File: rtl/cu_edge_sum_accumulate_if.sv
// Bus bundle between an edge-sum compute unit and its vertex source, edge FIFO and result sink.
// The master modport is the compute-unit side.
interface cu_edge_sum_accumulate_if #(
   parameter int EDGE_SIZE_BITS = 32,
   parameter int WEIGHT_BITS    = 32,
   parameter int SUM_BITS       = 64
);
   typedef struct packed {
      logic                      valid;
      logic [EDGE_SIZE_BITS-1:0] id;
      logic [EDGE_SIZE_BITS-1:0] inverse_out_degree;
   } VertexInterface;

   typedef struct packed {
      logic empty;
      logic full;
   } BufferStatus;

   typedef struct packed {
      logic                      valid;
      logic [EDGE_SIZE_BITS-1:0] id;
      logic [EDGE_SIZE_BITS-1:0] src;
      logic [EDGE_SIZE_BITS-1:0] dest;
      logic [WEIGHT_BITS-1:0]    weight;
   } EdgeInterface;

   VertexInterface            vertex_job;
   logic                      vertex_job_ack;
   BufferStatus               edge_buffer_status;
   EdgeInterface              edge_job;
   logic                      edge_request;
   logic                      result_valid;
   logic                      result_ready;
   logic [EDGE_SIZE_BITS-1:0] result_vertex_id;
   logic [SUM_BITS-1:0]       result_sum;
   logic [EDGE_SIZE_BITS-1:0] result_edge_count;
   logic [7:0]                result_cu_id;

   modport master (
      input  vertex_job, edge_buffer_status, edge_job, result_ready,
      output vertex_job_ack, edge_request, result_valid,
             result_vertex_id, result_sum, result_edge_count, result_cu_id
   );

   modport slave (
      output vertex_job, edge_buffer_status, edge_job, result_ready,
      input  vertex_job_ack, edge_request, result_valid,
             result_vertex_id, result_sum, result_edge_count, result_cu_id
   );
endinterface

// File: rtl/cu_edge_sum_accumulate.sv
// Per-vertex edge weight accumulator: pops out-degree edges from an upstream FIFO with
// bounded outstanding requests, sums their weights and emits one result per vertex.
module cu_edge_sum_accumulate #(
   parameter int CU_ID          = 1,
   parameter int EDGE_SIZE_BITS = 32,
   parameter int WEIGHT_BITS    = 32,
   parameter int SUM_BITS       = 64,
   parameter int MAX_INFLIGHT   = 4
) (
   input  logic                     clock,
   input  logic                     rstn,
   input  logic                     enabled,
   cu_edge_sum_accumulate_if.master bus,
   output logic                     err_dest_mismatch,
   output logic                     err_unexpected_edge
);
   localparam int IW = $clog2(MAX_INFLIGHT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, ACCUM, DRAIN, EMIT} state_e;

   state_e                    state_q, state_d;
   logic [EDGE_SIZE_BITS-1:0] vid_q, vid_d, deg_q, deg_d;
   logic [EDGE_SIZE_BITS-1:0] req_q, req_d, rcv_q, rcv_d;
   logic [IW-1:0]             infl_q, infl_d;
   logic [SUM_BITS-1:0]       sum_q, sum_d;
   logic                      edge_req_q, edge_req_d;
   logic                      ack_q, ack_d;
   logic                      rvalid_q, rvalid_d;
   logic [EDGE_SIZE_BITS-1:0] res_vid_q, res_vid_d, res_cnt_q, res_cnt_d;
   logic [SUM_BITS-1:0]       res_sum_q, res_sum_d;
   logic [7:0]                res_cu_q, res_cu_d;
   logic                      err_dest_q, err_dest_d, err_unexp_q, err_unexp_d;
   logic                      issue, take;

   logic unused_bits;
   assign unused_bits = ^{bus.edge_job.id, bus.edge_job.src, bus.edge_buffer_status.full};

   always_comb begin
      state_d     = state_q;
      vid_d       = vid_q;
      deg_d       = deg_q;
      req_d       = req_q;
      rcv_d       = rcv_q;
      infl_d      = infl_q;
      sum_d       = sum_q;
      edge_req_d  = 1'b0;
      ack_d       = enabled ? 1'b0 : ack_q;
      rvalid_d    = rvalid_q;
      res_vid_d   = res_vid_q;
      res_cnt_d   = res_cnt_q;
      res_sum_d   = res_sum_q;
      res_cu_d    = res_cu_q;
      err_dest_d  = err_dest_q;
      err_unexp_d = err_unexp_q;

      issue = enabled && (state_q == ACCUM) && !bus.edge_buffer_status.empty &&
              (infl_q < IW'(MAX_INFLIGHT)) && (req_q < deg_q);
      // Returning edges are absorbed even while disabled, so inflight never goes stale.
      take  = bus.edge_job.valid && ((state_q == ACCUM) || (state_q == DRAIN)) &&
              (infl_q != '0);

      if (issue) begin
         edge_req_d = 1'b1;
         req_d      = req_q + EDGE_SIZE_BITS'(1);
      end
      if (issue && !take)      infl_d = infl_q + IW'(1);
      else if (take && !issue) infl_d = infl_q - IW'(1);

      if (take) begin
         sum_d = sum_q + SUM_BITS'(bus.edge_job.weight);
         rcv_d = rcv_q + EDGE_SIZE_BITS'(1);
         if (bus.edge_job.dest != vid_q) err_dest_d = 1'b1;
      end else if (bus.edge_job.valid) begin
         err_unexp_d = 1'b1;
      end

      if (enabled) begin
         unique case (state_q)
            IDLE: if (bus.vertex_job.valid) begin
               vid_d   = bus.vertex_job.id;
               deg_d   = bus.vertex_job.inverse_out_degree;
               sum_d   = '0;
               req_d   = '0;
               rcv_d   = '0;
               ack_d   = 1'b1;
               state_d = LOAD;
            end
            LOAD:  state_d = (deg_q == '0) ? EMIT : ACCUM;
            ACCUM: if (req_q == deg_q) state_d = DRAIN;
            DRAIN: if ((rcv_q == deg_q) && (infl_q == '0)) state_d = EMIT;
            EMIT: begin
               // First EMIT cycle snapshots the payload; it then holds until the handshake.
               if (!rvalid_q) begin
                  rvalid_d  = 1'b1;
                  res_vid_d = vid_q;
                  res_sum_d = sum_q;
                  res_cnt_d = rcv_q;
                  res_cu_d  = 8'(CU_ID);
               end else if (bus.result_ready) begin
                  rvalid_d = 1'b0;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         vid_q       <= '0;
         deg_q       <= '0;
         req_q       <= '0;
         rcv_q       <= '0;
         infl_q      <= '0;
         sum_q       <= '0;
         edge_req_q  <= 1'b0;
         ack_q       <= 1'b0;
         rvalid_q    <= 1'b0;
         res_vid_q   <= '0;
         res_cnt_q   <= '0;
         res_sum_q   <= '0;
         res_cu_q    <= '0;
         err_dest_q  <= 1'b0;
         err_unexp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vid_q       <= vid_d;
         deg_q       <= deg_d;
         req_q       <= req_d;
         rcv_q       <= rcv_d;
         infl_q      <= infl_d;
         sum_q       <= sum_d;
         edge_req_q  <= edge_req_d;
         ack_q       <= ack_d;
         rvalid_q    <= rvalid_d;
         res_vid_q   <= res_vid_d;
         res_cnt_q   <= res_cnt_d;
         res_sum_q   <= res_sum_d;
         res_cu_q    <= res_cu_d;
         err_dest_q  <= err_dest_d;
         err_unexp_q <= err_unexp_d;
      end
   end

   assign bus.edge_request      = edge_req_q;
   assign bus.vertex_job_ack    = ack_q;
   assign bus.result_valid      = rvalid_q;
   assign bus.result_vertex_id  = res_vid_q;
   assign bus.result_sum        = res_sum_q;
   assign bus.result_edge_count = res_cnt_q;
   assign bus.result_cu_id      = res_cu_q;
   assign err_dest_mismatch     = err_dest_q;
   assign err_unexpected_edge   = err_unexp_q;
endmodule

// File: tb/tb_cu_edge_sum_accumulate.sv
// Directed bench for cu_edge_sum_accumulate: an edge-FIFO responder with programmable pop
// latency, a result/error model derived from the edge lists, and a per-cycle compare process.
module tb_cu_edge_sum_accumulate;
   localparam int MAXI = 4;

   logic clock = 1'b0;
   logic rstn, enabled;
   logic err_dm, err_ue;

   cu_edge_sum_accumulate_if #(.EDGE_SIZE_BITS(32), .WEIGHT_BITS(32), .SUM_BITS(64)) bus ();

   cu_edge_sum_accumulate #(.CU_ID(1), .EDGE_SIZE_BITS(32), .WEIGHT_BITS(32), .SUM_BITS(64),
                            .MAX_INFLIGHT(MAXI)) dut (
      .clock(clock), .rstn(rstn), .enabled(enabled), .bus(bus),
      .err_dest_mismatch(err_dm), .err_unexpected_edge(err_ue));

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          due;
      int          gen;
      logic [31:0] dest;
      logic [31:0] w;
      bit          stale;
   } pend_t;

   // Written by main only
   logic [31:0] ew[$];
   logic [31:0] ed[$];
   int          lat = 1;
   int          job_seq = 0;
   int          inj_seq = 0;
   pend_t       inj_e;
   logic [31:0] cur_vid = '0;
   logic [63:0] exp_sum = '0;
   logic [31:0] exp_cnt = '0;

   // Written by the responder only
   pend_t pend[$];
   pend_t drv, p;
   int    cyc = 0, pops = 0, rx = 0, max_out = 0, eidx = 0, seen_seq = 0, inj_done = 0;
   int    cur_gen = 0;
   bit    exp_dm = 0, exp_ue = 0;

   // Written by the compare process only
   int          vcyc = 0, ack_cyc = 0, rise_cyc = 0;
   logic [63:0] last_sum = '0;
   logic [31:0] last_cnt = '0;
   bit          prev_v = 0, prev_r = 0;
   logic [63:0] prev_sum;
   logic [31:0] prev_vid, prev_cnt;

   // Edge FIFO responder and error-flag model
   initial begin
      bus.edge_job = '0;
      forever begin
         @(posedge clock);
         cyc++;
         if (job_seq != seen_seq) begin
            seen_seq = job_seq;
            eidx     = 0;
         end
         if (bus.edge_job.valid) begin
            rx++;
            if (rstn) begin
               if (drv.stale || drv.gen != cur_gen) exp_ue = 1;
               else if (drv.dest != cur_vid)        exp_dm = 1;
            end
         end
         if (!rstn) begin
            exp_dm = 0;
            exp_ue = 0;
            cur_gen++;
         end
         if (bus.edge_request) begin
            pops++;
            p.due   = cyc + lat;
            p.gen   = cur_gen;
            p.stale = 0;
            p.dest  = (eidx < ed.size()) ? ed[eidx] : 32'd0;
            p.w     = (eidx < ew.size()) ? ew[eidx] : 32'd0;
            pend.push_back(p);
            eidx++;
         end
         if (pops - rx > max_out) max_out = pops - rx;
         #1;
         bus.edge_job = '0;
         if (inj_seq != inj_done) begin
            inj_done = inj_seq;
            drv = inj_e;
            bus.edge_job.valid  = 1'b1;
            bus.edge_job.dest   = drv.dest;
            bus.edge_job.weight = drv.w;
         end else if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            drv = pend.pop_front();
            bus.edge_job.valid  = 1'b1;
            bus.edge_job.dest   = drv.dest;
            bus.edge_job.weight = drv.w;
         end
      end
   end

   // Per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clock);
         if (!rstn) begin
            chk("rst_edge_request", bus.edge_request, 0);
            chk("rst_ack", bus.vertex_job_ack, 0);
            chk("rst_result_valid", bus.result_valid, 0);
            chk("rst_result_sum", bus.result_sum, 0);
            chk("rst_result_vid", bus.result_vertex_id, 0);
            chk("rst_result_cnt", bus.result_edge_count, 0);
            chk("rst_result_cu", bus.result_cu_id, 0);
            chk("rst_err_dm", err_dm, 0);
            chk("rst_err_ue", err_ue, 0);
            prev_v = 0;
         end else begin
            chk("err_dest_mismatch", err_dm, exp_dm);
            chk("err_unexpected_edge", err_ue, exp_ue);
            if (prev_v && !prev_r) begin
               chk("valid_held", bus.result_valid, 1);
               chk("stable_sum", bus.result_sum, prev_sum);
               chk("stable_vid", bus.result_vertex_id, prev_vid);
               chk("stable_cnt", bus.result_edge_count, prev_cnt);
            end
            if (bus.vertex_job_ack) ack_cyc = cyc;
            if (bus.result_valid) begin
               vcyc++;
               if (!prev_v) rise_cyc = cyc;
               chk("result_vid", bus.result_vertex_id, cur_vid);
               chk("result_sum", bus.result_sum, exp_sum);
               chk("result_cnt", bus.result_edge_count, exp_cnt);
               chk("result_cu", bus.result_cu_id, 1);
               last_sum = bus.result_sum;
               last_cnt = bus.result_edge_count;
            end
            prev_v   = bus.result_valid;
            prev_r   = bus.result_ready;
            prev_sum = bus.result_sum;
            prev_vid = bus.result_vertex_id;
            prev_cnt = bus.result_edge_count;
         end
      end
   end

   int p0, v0;

   task automatic start_job(input logic [31:0] vid, input int l);
      int guard;
      lat     = l;
      cur_vid = vid;
      exp_cnt = 32'(ew.size());
      exp_sum = '0;
      foreach (ew[i]) exp_sum = exp_sum + {32'd0, ew[i]};
      job_seq++;
      p0 = pops;
      v0 = vcyc;
      bus.vertex_job.valid              = 1'b1;
      bus.vertex_job.id                 = vid;
      bus.vertex_job.inverse_out_degree = 32'(ew.size());
      guard = 0;
      while (!bus.vertex_job_ack && guard < 20) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("ack_seen", guard < 20, 1);
      bus.vertex_job.valid = 1'b0;
   endtask

   task automatic run_vertex(input logic [31:0] vid, input int hold, input int l);
      int guard;
      bus.result_ready = (hold == 0);
      start_job(vid, l);
      guard = 0;
      while (!bus.result_valid && guard < 300) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("result_seen", guard < 300, 1);
      if (hold > 0) begin
         repeat (hold) @(posedge clock);
         #1 bus.result_ready = 1'b1;
      end
      guard = 0;
      while (bus.result_valid && guard < 50) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("result_done", guard < 50, 1);
      bus.result_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      rstn = 1'b0;
      enabled = 1'b1;
      bus.vertex_job = '0;
      bus.edge_buffer_status = '0;
      bus.result_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 rstn = 1'b1;
      @(posedge clock); #1;

      // Degree 3, weights 5,7,9
      ew = '{32'd5, 32'd7, 32'd9};
      ed = '{32'h7, 32'h7, 32'h7};
      run_vertex(32'h7, 0, 1);
      chk("t1_model_sum", exp_sum, 64'd21);
      chk("t1_pops", pops - p0, 3);
      chk("t1_sum", last_sum, 64'd21);
      chk("t1_cnt", last_cnt, 3);
      chk("t1_valid_cycles", vcyc - v0, 1);

      // Degree 0
      ew = {};
      ed = {};
      run_vertex(32'h9, 0, 1);
      chk("t2_pops", pops - p0, 0);
      chk("t2_sum", last_sum, 0);
      chk("t2_cnt", last_cnt, 0);
      chk("t2_ack_to_valid", rise_cyc - ack_cyc, 2);

      // Degree 10, latency 3, FIFO briefly empty
      ew = {};
      ed = {};
      for (int i = 0; i < 10; i++) begin
         ew.push_back(32'(i * 3 + 1));
         ed.push_back(32'h20);
      end
      fork
         run_vertex(32'h20, 0, 3);
         begin
            repeat (4) @(posedge clock);
            #1 bus.edge_buffer_status.empty = 1'b1;
            repeat (3) @(posedge clock);
            #1 bus.edge_buffer_status.empty = 1'b0;
         end
      join
      chk("t3_model_sum", exp_sum, 64'd145);
      chk("t3_pops", pops - p0, 10);
      chk("t3_cnt", last_cnt, 10);
      chk("t3_sum", last_sum, 64'd145);
      chk("t3_max_inflight", max_out <= MAXI, 1);

      // Enable dropped mid-vertex
      ew = '{32'd100, 32'd200, 32'd300, 32'd400};
      ed = '{32'h30, 32'h30, 32'h30, 32'h30};
      fork
         run_vertex(32'h30, 0, 2);
         begin
            repeat (3) @(posedge clock);
            #1 enabled = 1'b0;
            @(posedge clock); #1;
            chk("t4_no_pop_disabled", bus.edge_request, 0);
            repeat (3) @(posedge clock);
            #1 enabled = 1'b1;
         end
      join
      chk("t4_sum", last_sum, 64'd1000);
      chk("t4_pops", pops - p0, 4);

      // Wrap-free 64-bit sum with backpressure
      ew = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
      ed = '{32'h40, 32'h40};
      run_vertex(32'h40, 5, 1);
      chk("t5_model_sum", exp_sum, 64'h1_FFFF_FFFE);
      chk("t5_sum", last_sum, 64'h1_FFFF_FFFE);
      chk("t5_valid_cycles", vcyc - v0, 6);

      // Destination mismatch, then sticky across the next vertex
      ew = '{32'd1, 32'd2};
      ed = '{32'h50, 32'h51};
      run_vertex(32'h50, 0, 1);
      chk("t6_err_dm", err_dm, 1);
      chk("t6_sum", last_sum, 64'd3);
      ew = '{32'd11};
      ed = '{32'h60};
      run_vertex(32'h60, 0, 1);
      chk("t6_err_dm_sticky", err_dm, 1);

      // Edge arriving while idle
      inj_e.dest  = 32'h0;
      inj_e.w     = 32'd5;
      inj_e.gen   = 0;
      inj_e.due   = 0;
      inj_e.stale = 1;
      inj_seq++;
      repeat (3) @(posedge clock); #1;
      chk("t7_err_ue", err_ue, 1);

      // Reset mid-ACCUM with edges still in flight
      ew = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
      ed = '{32'h70, 32'h70, 32'h70, 32'h70, 32'h70, 32'h70};
      start_job(32'h70, 6);
      repeat (4) @(posedge clock); #1;
      chk("t8_pops_before_reset", (pops - p0) >= 1, 1);
      rstn = 1'b0;
      #1;
      chk("t8_rst_req", bus.edge_request, 0);
      chk("t8_rst_valid", bus.result_valid, 0);
      chk("t8_rst_err_dm", err_dm, 0);
      chk("t8_rst_err_ue", err_ue, 0);
      @(posedge clock);
      #1 rstn = 1'b1;
      repeat (12) @(posedge clock); #1;
      chk("t8_stale_edge_flag", err_ue, 1);
      chk("t8_no_result", bus.result_valid, 0);

      // Fresh vertex after reset proves the FSM returned to IDLE
      ew = '{32'd3, 32'd4};
      ed = '{32'h80, 32'h80};
      run_vertex(32'h80, 0, 1);
      chk("t9_sum", last_sum, 64'd7);
      chk("t9_cnt", last_cnt, 2);

      repeat (2) @(posedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cu_edge_sum_accumulate.md
CU_EDGE_SUM_ACCUMULATE -- requirements
Module: cu_edge_sum_accumulate

Interface
REQ-001 SHALL have parameter CU_ID, default 1: compute-unit tag copied into every result.
REQ-002 SHALL have parameter EDGE_SIZE_BITS, default 32: width of edge/vertex ids, degree and counters.
REQ-003 SHALL have parameter WEIGHT_BITS, default 32: width of edge weight.
REQ-004 SHALL have parameter SUM_BITS, default 64: width of the weight accumulator.
REQ-005 SHALL have parameter MAX_INFLIGHT, default 4: maximum pops issued but not yet returned.
REQ-006 SHALL have port clock  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rstn  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port enabled  in  1  global enable; low freezes all state.
REQ-009 SHALL have port vertex_job  in  VertexInterface  current vertex: valid, id, inverse_out_degree.
REQ-010 SHALL have port vertex_job_ack  out  1  one-cycle pulse when a vertex job is accepted.
REQ-011 SHALL have port edge_buffer_status  in  BufferStatus  upstream edge FIFO status; only empty is used.
REQ-012 SHALL have port edge_job  in  EdgeInterface  popped edge: valid, id, src, dest, weight.
REQ-013 SHALL have port edge_request  out  1  registered pop strobe to the upstream edge FIFO.
REQ-014 SHALL have port result_valid / result_ready  out / in  1 / 1  result handshake.
REQ-015 SHALL have port result_vertex_id, result_sum, result_edge_count, result_cu_id  out  EDGE_SIZE_BITS, SUM_BITS, EDGE_SIZE_BITS, 8  result payload.
REQ-016 SHALL have port err_dest_mismatch, err_unexpected_edge  out  1 each  sticky error flags.

Function
REQ-017 SHALL implement states IDLE, LOAD, ACCUM, DRAIN, EMIT.
REQ-018 In IDLE with vertex_job.valid, SHALL latch id and degree, pulse vertex_job_ack, clear sum/requested/received counters, and go to LOAD.
REQ-019 LOAD: degree==0 -> EMIT (sum 0, count 0); else -> ACCUM.
REQ-020 In ACCUM, edge_request SHALL assert next cycle iff ~edge_buffer_status.empty, inflight<MAX_INFLIGHT, requested<degree, and enabled.
REQ-021 requested SHALL increment per edge_request; inflight +1 per edge_request, -1 per edge_job.valid; both in one cycle leaves inflight unchanged.
REQ-022 Per edge_job.valid in ACCUM/DRAIN: sum += zero-extended weight, wrapping mod 2^SUM_BITS; received += 1.
REQ-023 If an accepted edge has dest != latched vertex id, SHALL set err_dest_mismatch and still accumulate.
REQ-024 ACCUM -> DRAIN once requested==degree; DRAIN -> EMIT when received==degree and inflight==0.
REQ-025 In EMIT, result_valid SHALL be held high, payload stable, until result_ready is high; then return to IDLE the next cycle.
REQ-026 edge_job.valid in IDLE, LOAD or EMIT, or with inflight==0, SHALL set err_unexpected_edge and be discarded.
REQ-027 Pop-to-data latency is any value >=1 cycle; correctness SHALL NOT depend on it.
REQ-028 enabled low SHALL hold state, counters and outputs, and force edge_request low; edges arriving then are still accumulated.
REQ-029 A new vertex job SHALL NOT be accepted before the previous result handshake completes.

Reset
REQ-030 rstn low SHALL asynchronously force IDLE; edge_request, vertex_job_ack, result_valid, all payload, counters, sum and error flags to 0.
REQ-031 Reset mid-vertex SHALL abandon the vertex; in-flight edges returning after reset SHALL set err_unexpected_edge.

Verification
REQ-032 Degree 3, weights 5,7,9, FIFO never empty, result_ready=1 -> exactly 3 pops, result_sum=21, count=3, one result_valid cycle.
REQ-033 Degree 0 -> no pops, result_valid with sum 0, count 0, two cycles after ack.
REQ-034 Degree 10, pop latency 3 cycles, MAX_INFLIGHT=4 -> inflight never exceeds 4, exactly 10 pops, count=10.
REQ-035 Degree 2, weights 0xFFFFFFFF each, SUM_BITS=64 -> result_sum=0x1_FFFFFFFE; result_ready low 5 cycles -> payload stable throughout.
REQ-036 Edge with dest!=vertex id -> err_dest_mismatch=1 and sticky; rstn pulse mid-ACCUM -> all outputs 0, state IDLE.
